// File: rtl/usr_shift_sequencer_if.sv
// Purpose: command handshake and register-drive bundle for usr_shift_sequencer.
// Latency: none; wires only.
// Backpressure: cmd_ready (slave output) gates cmd_valid (master output).
//
// Ports:
//   Command side   : cmd_valid, cmd_ready, cmd_op, cmd_count, cmd_data
//   Register side  : Sel, P_in, R_Shift, L_Shift driven to the register;
//                    reg_q is the register's Out fed back
//   Status         : Busy, Done
// Modports:
//   slave  - the sequencer
//   master - the host plus the attached shift register
interface usr_shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] reg_q;
    logic [1:0]       Sel;
    logic [WIDTH-1:0] P_in;
    logic             R_Shift;
    logic             L_Shift;
    logic             Busy;
    logic             Done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, reg_q,
        output cmd_ready, Sel, P_in, R_Shift, L_Shift, Busy, Done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, reg_q,
        input  cmd_ready, Sel, P_in, R_Shift, L_Shift, Busy, Done
    );
endinterface

// File: rtl/usr_shift_sequencer.sv
// Purpose: steps a 4-bit universal shift register through load / shift-N / no-op commands.
// Latency: accept->Done = 2 (load), N+1 (shift N), 1 (no-op or zero count).
// Backpressure: cmd_ready low while Busy; cmd_valid seen while Busy is dropped, not queued.
//
// Ports:
//   Clk, Rst_n      clock and asynchronous active-low reset
//   bus (slave)     command handshake in, register controls out, reg_q feedback in
//
// Optional build macro USR_SEQ_ROTATE_EN:
//   cmd_data[WIDTH-1] becomes a rotate flag for shift ops and the serial
//   bit is taken combinationally from reg_q; without it reg_q is unused and
//   every output is a flop.
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    usr_shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Op codes double as the register's Sel encoding.
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_LEFT  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    state_t           state_q,   state_d;
    logic [1:0]       op_q,      op_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] pat_q,     pat_d;
    logic [WIDTH-1:0] p_in_q,    p_in_d;
    logic [1:0]       sel_q,     sel_d;
    logic             r_shift_q, r_shift_d;
    logic             l_shift_q, l_shift_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [WIDTH-1:0] cmd_pat;
    logic             cmd_is_shift;

    assign cmd_is_shift = (bus.cmd_op == OP_RIGHT) || (bus.cmd_op == OP_LEFT);

`ifdef USR_SEQ_ROTATE_EN
    // Top data bit is the rotate flag, so it never enters the pattern.
    assign cmd_pat = {1'b0, bus.cmd_data[WIDTH-2:0]};
`else
    assign cmd_pat = bus.cmd_data;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        p_in_d  = p_in_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d  = bus.cmd_op;
                    cnt_d = bus.cmd_count;
                    pat_d = cmd_pat;
                    if (bus.cmd_op == OP_LOAD) begin
                        // P_in only follows load data so it stays put otherwise.
                        p_in_d  = bus.cmd_data;
                        state_d = ST_LOAD;
                    end else if (cmd_is_shift && (bus.cmd_count != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_LOAD: begin
                state_d = ST_DONE;
            end

            ST_SHIFT: begin
                // Zero fill: counts beyond WIDTH feed zeros once the pattern runs out.
                pat_d = pat_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the *next* state so the outputs come straight
    // off flops and line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        sel_d     = OP_NOP;
        r_shift_d = 1'b0;
        l_shift_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        case (state_d)
            ST_LOAD: begin
                sel_d = OP_LOAD;
            end
            ST_SHIFT: begin
                sel_d     = op_d;
                r_shift_d = (op_d == OP_RIGHT) && pat_d[0];
                l_shift_d = (op_d == OP_LEFT)  && pat_d[0];
            end
            default: begin
                sel_d = OP_NOP;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            cnt_q     <= '0;
            pat_q     <= '0;
            p_in_q    <= '0;
            sel_q     <= OP_NOP;
            r_shift_q <= 1'b0;
            l_shift_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            p_in_q    <= p_in_d;
            sel_q     <= sel_d;
            r_shift_q <= r_shift_d;
            l_shift_q <= l_shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.Sel       = sel_q;
    assign bus.P_in      = p_in_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.cmd_ready = ~busy_q;

`ifdef USR_SEQ_ROTATE_EN
    logic rot_q, rot_d;

    always_comb begin
        rot_d = rot_q;
        if ((state_q == ST_IDLE) && bus.cmd_valid) begin
            rot_d = cmd_is_shift && bus.cmd_data[WIDTH-1];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end

    // Rotating feeds the bit falling off one end back into the other, so it
    // must come live from the register rather than from the pattern.
    assign bus.R_Shift = (rot_q && (sel_q == OP_RIGHT)) ? bus.reg_q[0]       : r_shift_q;
    assign bus.L_Shift = (rot_q && (sel_q == OP_LEFT))  ? bus.reg_q[WIDTH-1] : l_shift_q;
`else
    logic unused_reg_q;
    assign unused_reg_q = ^bus.reg_q;

    assign bus.R_Shift = r_shift_q;
    assign bus.L_Shift = l_shift_q;
`endif

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Purpose: randomized self-checking bench for usr_shift_sequencer with an attached register model.
// Latency: checks accept->Done latency and per-cycle Sel/serial activity per command.
// Backpressure: drives cmd_valid noise while busy and holds it high across commands.
module tb_usr_shift_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // exp_reg: what the register should hold according to the command history.
    // out_r  : the shift register the sequencer is steering.
    logic [WIDTH-1:0] exp_reg = '0;
    logic [WIDTH-1:0] out_r   = '0;

    always #5 clk = ~clk;

    usr_shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    // Universal shift register: right shift enters at the MSB, left at the LSB.
    always @(posedge clk) begin
        case (bus.Sel)
            2'b01:   out_r <= {bus.R_Shift, out_r[WIDTH-1:1]};
            2'b10:   out_r <= {out_r[WIDTH-2:0], bus.L_Shift};
            2'b11:   out_r <= bus.P_in;
            default: out_r <= out_r;
        endcase
    end
    assign bus.reg_q = out_r;

    // Register contents after a whole command, from the command rules alone.
    function automatic logic [WIDTH-1:0] model_final(input logic [1:0] op, input int cnt,
                                                     input logic [WIDTH-1:0] data,
                                                     input logic [WIDTH-1:0] start);
        logic [WIDTH-1:0] v   = start;
        logic [WIDTH-1:0] pat = data;
        bit rot = 1'b0;
        bit b;
        if (op == 2'b11) return data;
        if (op == 2'b00) return start;
`ifdef USR_SEQ_ROTATE_EN
        rot = data[WIDTH-1];
        pat[WIDTH-1] = 1'b0;
`endif
        for (int i = 0; i < cnt; i++) begin
            b = (i < WIDTH) ? pat[i] : 1'b0;
            if (op == 2'b01) begin
                if (rot) b = v[0];
                v = (v >> 1) | (WIDTH'(b) << (WIDTH - 1));
            end else begin
                if (rot) b = v[WIDTH-1];
                v = (v << 1) | WIDTH'(b);
            end
        end
        return v;
    endfunction

    task automatic scramble_fields();
        bus.cmd_op    = 2'($urandom);
        bus.cmd_count = CNT_W'($urandom);
        bus.cmd_data  = WIDTH'($urandom);
    endtask

    // Issues one command from a negedge and follows it to completion; returns at a negedge in IDLE.
    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                           input logic [WIDTH-1:0] data);
        int waited = 0;
        int cyc = 0;
        int act = 0;
        int bad_cyc = 0;
        int lat;
        int exp_lat;
        int exp_act;
        logic [1:0] exp_sel;
        logic [WIDTH-1:0] pat = data;
        logic [WIDTH-1:0] exp_fin;
        bit rot = 1'b0;
        bit seen = 1'b0;
        bit eb;
`ifdef USR_SEQ_ROTATE_EN
        if (op == 2'b01 || op == 2'b10) begin
            rot = data[WIDTH-1];
            pat[WIDTH-1] = 1'b0;
        end
`endif
        exp_fin = model_final(op, int'(cnt), data, exp_reg);
        if (op == 2'b11) begin
            exp_lat = 2; exp_act = 1; exp_sel = 2'b11;
        end else if (op != 2'b00 && cnt != 0) begin
            exp_lat = int'(cnt) + 1; exp_act = int'(cnt); exp_sel = op;
        end else begin
            exp_lat = 1; exp_act = 0; exp_sel = 2'b00;
        end

        while (bus.cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_wait: cmd_ready=%b required 1", bus.cmd_ready);
            return;
        end

        bus.cmd_op = op; bus.cmd_count = cnt; bus.cmd_data = data; bus.cmd_valid = 1'b1;
        @(negedge clk);
        // Fields only matter on the accept edge; garble them afterwards.
        bus.cmd_valid = 1'b0;
        scramble_fields();

        while (!seen && cyc < 40) begin
            cyc++;
            if (bus.Busy !== 1'b1 || bus.cmd_ready !== 1'b0) bad_cyc++;
            if (bus.Sel !== 2'b00) begin
                if (bus.Sel !== exp_sel) bad_cyc++;
                if (exp_sel == 2'b11 && bus.P_in !== data) bad_cyc++;
                if (exp_sel == 2'b01 || exp_sel == 2'b10) begin
                    eb = (act < WIDTH) ? pat[act] : 1'b0;
                    if (exp_sel == 2'b01) begin
                        if (!rot && bus.R_Shift !== eb) bad_cyc++;
                        if (bus.L_Shift !== 1'b0) bad_cyc++;
                    end else begin
                        if (!rot && bus.L_Shift !== eb) bad_cyc++;
                        if (bus.R_Shift !== 1'b0) bad_cyc++;
                    end
                end
                act++;
            end
            if (bus.Done === 1'b1) begin
                seen = 1'b1;
                bus.cmd_valid = 1'b0;
            end else begin
                // Busy: this noise must be ignored.
                bus.cmd_valid = 1'($urandom_range(0, 1));
                scramble_fields();
                @(negedge clk);
            end
        end
        lat = seen ? cyc : -1;

        n_cmp++;
        if (lat != exp_lat)
            begin n_bad++; $display("FAIL latency op=%0d cnt=%0d: got %0d required %0d", op, cnt, lat, exp_lat); end
        n_cmp++;
        if (act != exp_act)
            begin n_bad++; $display("FAIL active_cycles op=%0d cnt=%0d: got %0d required %0d", op, cnt, act, exp_act); end
        n_cmp++;
        if (bad_cyc != 0)
            begin n_bad++; $display("FAIL cycle_outputs op=%0d cnt=%0d data=%b: %0d bad cycles required 0", op, cnt, data, bad_cyc); end
        n_cmp++;
        if (out_r !== exp_fin)
            begin n_bad++; $display("FAIL reg_value op=%0d cnt=%0d data=%b: got %b required %b", op, cnt, data, out_r, exp_fin); end

        @(negedge clk);
        n_cmp++;
        if ({bus.Done, bus.Busy, bus.cmd_ready, bus.Sel} !== 5'b00100)
            begin n_bad++; $display("FAIL idle_return: Done/Busy/ready/Sel=%b required 00100",
                                   {bus.Done, bus.Busy, bus.cmd_ready, bus.Sel}); end
        exp_reg = exp_fin;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        scramble_fields();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.Sel, bus.P_in, bus.R_Shift, bus.L_Shift, bus.Busy, bus.Done, bus.cmd_ready}
                !== {2'b00, {WIDTH{1'b0}}, 5'b00001})
            begin n_bad++; $display("FAIL reset_values: got %b required %b",
                {bus.Sel, bus.P_in, bus.R_Shift, bus.L_Shift, bus.Busy, bus.Done, bus.cmd_ready},
                {2'b00, {WIDTH{1'b0}}, 5'b00001}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || bus.Busy !== 1'b0)
            begin n_bad++; $display("FAIL reset_release: ready=%b busy=%b required 1 0", bus.cmd_ready, bus.Busy); end
    endtask

    task automatic test_reset_mid_shift();
        bus.cmd_op = 2'b01; bus.cmd_count = 3'd5; bus.cmd_data = WIDTH'($urandom); bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b1 || bus.Sel !== 2'b01)
            begin n_bad++; $display("FAIL mid_shift_active: busy=%b sel=%b required 1 01", bus.Busy, bus.Sel); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.Sel, bus.P_in, bus.R_Shift, bus.L_Shift, bus.Busy, bus.Done, bus.cmd_ready}
                !== {2'b00, {WIDTH{1'b0}}, 5'b00001})
            begin n_bad++; $display("FAIL async_reset: got %b required %b",
                {bus.Sel, bus.P_in, bus.R_Shift, bus.L_Shift, bus.Busy, bus.Done, bus.cmd_ready},
                {2'b00, {WIDTH{1'b0}}, 5'b00001}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.cmd_ready !== 1'b1 || bus.Busy !== 1'b0)
            begin n_bad++; $display("FAIL reset_mid_release: ready=%b busy=%b required 1 0", bus.cmd_ready, bus.Busy); end
        // Register content after an aborted shift is not tracked; a load resyncs it.
        run_cmd(2'b11, 3'd0, WIDTH'($urandom));
    endtask

    task automatic test_load();
        run_cmd(2'b11, 3'd0, 4'b0111);
    endtask

    task automatic test_shift_right();
        run_cmd(2'b11, 3'd0, 4'b0000);
        run_cmd(2'b01, 3'd4, 4'b0111);
    endtask

    task automatic test_shift_left();
        run_cmd(2'b11, 3'd0, 4'b0000);
        run_cmd(2'b10, 3'd6, 4'b0101);
        run_cmd(2'b10, 3'd7, 4'b1111);
    endtask

    task automatic test_zero_count();
        run_cmd(2'b01, 3'd0, WIDTH'($urandom));
        run_cmd(2'b10, 3'd0, WIDTH'($urandom));
        run_cmd(2'b00, 3'd5, WIDTH'($urandom));
    endtask

    task automatic test_back_to_back();
        int acc_idx[$];
        int dones = 0;
        int bad_gap = 0;
        logic [WIDTH-1:0] d = WIDTH'($urandom);
        bus.cmd_op = 2'b01; bus.cmd_count = 3'd2; bus.cmd_data = d; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                acc_idx.push_back(i);
                exp_reg = model_final(2'b01, 2, d, exp_reg);
            end
            if (bus.Done === 1'b1) dones++;
            if (i == 19) bus.cmd_valid = 1'b0;
            @(negedge clk);
        end
        for (int k = 1; k < acc_idx.size(); k++)
            if (acc_idx[k] - acc_idx[k-1] != 4) bad_gap++;
        n_cmp++;
        if (acc_idx.size() != 5)
            begin n_bad++; $display("FAIL b2b_accepts: got %0d required 5", acc_idx.size()); end
        n_cmp++;
        if (bad_gap != 0)
            begin n_bad++; $display("FAIL b2b_spacing: %0d gaps not 4 cycles, required 0", bad_gap); end
        n_cmp++;
        if (dones != 5)
            begin n_bad++; $display("FAIL b2b_dones: got %0d required 5", dones); end
        n_cmp++;
        if (out_r !== exp_reg)
            begin n_bad++; $display("FAIL b2b_reg: got %b required %b", out_r, exp_reg); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++)
            run_cmd(2'($urandom_range(0, 3)), CNT_W'($urandom), WIDTH'($urandom));
    endtask

`ifdef USR_SEQ_ROTATE_EN
    task automatic test_rotate();
        run_cmd(2'b11, 3'd0, 4'b1000);
        run_cmd(2'b01, 3'd4, 4'b1000);
        run_cmd(2'b10, 3'd3, 4'b1001);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_count = '0;
        bus.cmd_data  = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_shift_right();
        test_shift_left();
        test_zero_count();
        test_back_to_back();
        test_reset_mid_shift();
`ifdef USR_SEQ_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
